// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bit-controller command codes and byte-FSM state encoding.
package i2c_pkg;

  localparam logic [3:0] I2C_CMD_NOP   = 4'b0000;
  localparam logic [3:0] I2C_CMD_START = 4'b0001;
  localparam logic [3:0] I2C_CMD_STOP  = 4'b0010;
  localparam logic [3:0] I2C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] I2C_CMD_READ  = 4'b1000;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_START = 6'b000010,
    ST_READ  = 6'b000100,
    ST_WRITE = 6'b001000,
    ST_ACK   = 6'b010000,
    ST_STOP  = 6'b100000
  } byte_state_t;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master: expands a host byte request into START / 8 data bits / ACK / STOP
// bit commands, handshaking each with the bit controller.
module i2c_master_byte_ctrl
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       read,
  input  logic       write,
  input  logic       ack_in,
  input  logic [7:0] din,
  output logic       cmd_ack,
  output logic       ack_out,
  output logic [7:0] dout,
  output logic       busy,
  output logic [3:0] core_cmd,
  output logic       core_txd,
  input  logic       core_ack,
  input  logic       core_rxd,
  input  logic       core_al
);

  byte_state_t state, state_d;
  logic [3:0]  core_cmd_d;
  logic        cmd_ack_d;
  logic        ack_out_d;
  logic [7:0]  sr;
  logic [2:0]  cnt;
  logic        go;
  logic        cnt_done;

  // Gating by cmd_ack stops a request still held during the completion cycle from relaunching.
  assign go       = (start | stop | read | write) & ~cmd_ack;
  assign cnt_done = (cnt == 3'd0);
  assign dout     = sr;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    core_txd = 1'b1;
    if (state == ST_WRITE)
      core_txd = sr[7];
    else if (state == ST_ACK && read)
      core_txd = ack_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      core_cmd <= I2C_CMD_NOP;
      cmd_ack  <= 1'b0;
      ack_out  <= 1'b0;
    end else begin
      state    <= state_d;
      core_cmd <= core_cmd_d;
      cmd_ack  <= cmd_ack_d;
      ack_out  <= ack_out_d;
    end
  end

  always_comb begin
    state_d    = state;
    core_cmd_d = core_cmd;
    cmd_ack_d  = 1'b0;
    ack_out_d  = ack_out;
    if (core_al) begin
      state_d    = ST_IDLE;
      core_cmd_d = I2C_CMD_NOP;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (go) begin
            if (start) begin
              state_d    = ST_START;
              core_cmd_d = I2C_CMD_START;
            end else if (read) begin
              state_d    = ST_READ;
              core_cmd_d = I2C_CMD_READ;
            end else if (write) begin
              state_d    = ST_WRITE;
              core_cmd_d = I2C_CMD_WRITE;
            end else begin
              state_d    = ST_STOP;
              core_cmd_d = I2C_CMD_STOP;
            end
          end
        end
        ST_START: begin
          if (core_ack) begin
            if (read) begin
              state_d    = ST_READ;
              core_cmd_d = I2C_CMD_READ;
            end else begin
              state_d    = ST_WRITE;
              core_cmd_d = I2C_CMD_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (core_ack && cnt_done) begin
            state_d    = ST_ACK;
            core_cmd_d = I2C_CMD_READ;
          end
        end
        ST_READ: begin
          if (core_ack && cnt_done) begin
            state_d    = ST_ACK;
            core_cmd_d = I2C_CMD_WRITE;
          end
        end
        ST_ACK: begin
          if (core_ack) begin
            ack_out_d = core_rxd;
            if (stop) begin
              state_d    = ST_STOP;
              core_cmd_d = I2C_CMD_STOP;
            end else begin
              state_d    = ST_IDLE;
              core_cmd_d = I2C_CMD_NOP;
              cmd_ack_d  = 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (core_ack) begin
            state_d    = ST_IDLE;
            core_cmd_d = I2C_CMD_NOP;
            cmd_ack_d  = 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          core_cmd_d = I2C_CMD_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= 3'd7;
    end else if (!core_al) begin
      if (state == ST_IDLE && go) begin
        sr  <= din;
        cnt <= 3'd7;
      end else if (core_ack && (state == ST_READ || state == ST_WRITE)) begin
        sr  <= {sr[6:0], core_rxd};
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for i2c_master_byte_ctrl with a behavioural bit controller that acks each
// command 4 clocks after it appears.
module tb_i2c_master_byte_ctrl;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, read = 1'b0, write = 1'b0, ack_in = 1'b0;
  logic [7:0] din = '0;
  logic       cmd_ack, ack_out, busy, core_txd;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_ack = 1'b0, core_rxd = 1'b1, core_al = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  int ack_pulses = 0;

  logic [3:0] log_cmd[$];
  logic       log_txd[$];
  logic       rx_q[$];
  logic [3:0] exp_cmd[$];
  logic       exp_txd[$];

  i2c_master_byte_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din), .cmd_ack(cmd_ack), .ack_out(ack_out), .dout(dout),
    .busy(busy), .core_cmd(core_cmd), .core_txd(core_txd), .core_ack(core_ack),
    .core_rxd(core_rxd), .core_al(core_al)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (cmd_ack === 1'b1) ack_pulses++;
  end

  // Bit-controller model; abandons a command that is withdrawn (reset or arbitration loss).
  initial forever begin
    @(negedge clk);
    if (!rst && core_cmd != I2C_CMD_NOP) begin
      bit aborted = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (rst || core_cmd == I2C_CMD_NOP) begin
          aborted = 1'b1;
          break;
        end
      end
      if (!aborted) begin
        log_cmd.push_back(core_cmd);
        log_txd.push_back(core_txd);
        core_rxd = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b1;
        core_ack = 1'b1;
        last_ack_cyc = cyc;
        @(negedge clk);
        core_ack = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, log_cmd.size(), exp_cmd.size());
    for (int i = 0; i < exp_cmd.size() && i < log_cmd.size(); i++) begin
      check($sformatf("%s_cmd%0d", tag, i), {28'd0, log_cmd[i]}, {28'd0, exp_cmd[i]});
      check($sformatf("%s_txd%0d", tag, i), {31'd0, log_txd[i]}, {31'd0, exp_txd[i]});
    end
  endtask

  task automatic push_exp(input logic [3:0] c, input logic t);
    exp_cmd.push_back(c);
    exp_txd.push_back(t);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) push_exp(I2C_CMD_WRITE, b[i]);
  endtask

  task automatic clear_logs();
    log_cmd.delete(); log_txd.delete(); exp_cmd.delete(); exp_txd.delete(); rx_q.delete();
    ack_pulses = 0;
  endtask

  // Waits for cmd_ack, then checks completion latency and that no relaunch follows.
  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_cmd_ack_seen"}, {31'd0, seen}, 32'd1);
    if (seen) check({tag, "_ack_latency"}, cyc - last_ack_cyc, 32'd1);
  endtask

  task automatic finish_req(input string tag);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_cmd_ack_low"}, {31'd0, cmd_ack}, 32'd0);
    repeat (3) @(negedge clk);
    check({tag, "_no_relaunch"}, {31'd0, busy}, 32'd0);
    check({tag, "_pulses"}, ack_pulses, 32'd1);
  endtask

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    check("rst_cmd", {28'd0, core_cmd}, 32'd0);
    check("rst_cmd_ack", {31'd0, cmd_ack}, 32'd0);
    check("rst_ack_out", {31'd0, ack_out}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_txd", {31'd0, core_txd}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // START + write 0x00 + STOP with slave NACK: 11 handshakes.
    clear_logs();
    push_exp(I2C_CMD_START, 1'b1);
    push_byte(8'h00);
    push_exp(I2C_CMD_READ, 1'b1);
    push_exp(I2C_CMD_STOP, 1'b1);
    din = 8'h00; start = 1'b1; write = 1'b1; stop = 1'b1;
    wait_done("nack");
    check("nack_ack_out", {31'd0, ack_out}, 32'd1);
    finish_req("nack");
    check_log("nack");

    // START + write 0xA5, slave ACKs.
    clear_logs();
    push_exp(I2C_CMD_START, 1'b1);
    push_byte(8'hA5);
    push_exp(I2C_CMD_READ, 1'b1);
    for (int i = 0; i < 10; i++) rx_q.push_back(1'b0);
    din = 8'hA5; start = 1'b1; write = 1'b1;
    wait_done("wr_a5");
    check("wr_a5_ack_out", {31'd0, ack_out}, 32'd0);
    finish_req("wr_a5");
    check_log("wr_a5");

    // Read one byte, NACK it.
    clear_logs();
    for (int i = 0; i < 8; i++) push_exp(I2C_CMD_READ, 1'b1);
    push_exp(I2C_CMD_WRITE, 1'b1);
    rx_q = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ack_in = 1'b1; read = 1'b1;
    wait_done("rd");
    check("rd_dout", {24'd0, dout}, 32'h69);
    finish_req("rd");
    check_log("rd");

    // Reset in the middle of a read byte.
    clear_logs();
    read = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (log_cmd.size() >= 3);
    end
    check("mrst_progress", {31'd0, got}, 32'd1);
    @(negedge clk);
    rst = 1'b1; read = 1'b0;
    @(negedge clk);
    check("mrst_cmd", {28'd0, core_cmd}, 32'd0);
    check("mrst_cmd_ack", {31'd0, cmd_ack}, 32'd0);
    check("mrst_ack_out", {31'd0, ack_out}, 32'd0);
    check("mrst_dout", {24'd0, dout}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_txd", {31'd0, core_txd}, 32'd1);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Arbitration lost during bit 3 of a write.
    clear_logs();
    din = 8'hF0; write = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (log_cmd.size() >= 3);
    end
    check("al_progress", {31'd0, got}, 32'd1);
    @(negedge clk);
    core_al = 1'b1; write = 1'b0;
    @(negedge clk);
    core_al = 1'b0;
    check("al_busy", {31'd0, busy}, 32'd0);
    check("al_cmd", {28'd0, core_cmd}, 32'd0);
    check("al_cmd_ack", {31'd0, cmd_ack}, 32'd0);
    repeat (8) @(negedge clk);
    check("al_no_pulse", ack_pulses, 32'd0);
    check("al_idle", {31'd0, busy}, 32'd0);

    // Fresh write after the loss completes normally.
    clear_logs();
    push_byte(8'h3C);
    push_exp(I2C_CMD_READ, 1'b1);
    for (int i = 0; i < 9; i++) rx_q.push_back(1'b0);
    din = 8'h3C; write = 1'b1;
    wait_done("wr_3c");
    check("wr_3c_ack_out", {31'd0, ack_out}, 32'd0);
    finish_req("wr_3c");
    check_log("wr_3c");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
